// File: rtl/or1k_tlb_reload_arbiter_if.sv
// Bundle of the arbiter's walker-side reload ports and its Wishbone classic
// master port. The arbiter connects through the master modport; whatever sits
// around it (walkers plus bus slave) uses the slave modport.
interface or1k_tlb_reload_arbiter_if #(
    parameter int W = 32
);
    logic         immu_req_i;
    logic [W-1:0] immu_addr_i;
    logic         immu_ack_o;
    logic [W-1:0] immu_data_o;
    logic         immu_err_o;

    logic         dmmu_req_i;
    logic [W-1:0] dmmu_addr_i;
    logic         dmmu_ack_o;
    logic [W-1:0] dmmu_data_o;
    logic         dmmu_err_o;

    logic [W-1:0] wbm_adr_o;
    logic         wbm_cyc_o;
    logic         wbm_stb_o;
    logic         wbm_we_o;
    logic [3:0]   wbm_sel_o;
    logic [W-1:0] wbm_dat_i;
    logic         wbm_ack_i;
    logic         wbm_err_i;

    logic         busy_o;

    modport master (
        input  immu_req_i, immu_addr_i, dmmu_req_i, dmmu_addr_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output immu_ack_o, immu_data_o, immu_err_o,
        output dmmu_ack_o, dmmu_data_o, dmmu_err_o,
        output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        output busy_o
    );

    modport slave (
        output immu_req_i, immu_addr_i, dmmu_req_i, dmmu_addr_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  immu_ack_o, immu_data_o, immu_err_o,
        input  dmmu_ack_o, dmmu_data_o, dmmu_err_o,
        input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        input  busy_o
    );
endinterface

// File: rtl/or1k_tlb_reload_arbiter.sv
// Shared Wishbone read master for the IMMU/DMMU hardware TLB reload walkers.
// Round-robin arbitration in IDLE; the grant stays with one walker for its
// whole page walk. Optional bus watchdog: define OR1K_TLB_RELOAD_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no walk in progress, arbitrate between pending requests
// BUS     | Wishbone read outstanding (cyc/stb high) at the latched address
// RESP    | one-cycle ack (and err) to the owning walker
// LOCK    | walker updates addr or drops req; continue walk or release
module or1k_tlb_reload_arbiter #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input logic                        clk,
    input logic                        rst_n,
    or1k_tlb_reload_arbiter_if.master  bus
);
    localparam int W = OPTION_OPERAND_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_LOCK = 2'd3;

    localparam logic OWN_IMMU = 1'b0;
    localparam logic OWN_DMMU = 1'b1;

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]   r_state;
    logic         r_owner;
    logic         r_last;
    logic [W-1:2] r_adr;
    logic         r_cyc;
    logic         r_err;
    logic [W-1:0] r_immu_data;
    logic [W-1:0] r_dmmu_data;

    logic         w_owner_req;
    logic [W-1:0] w_owner_addr;
    logic         w_grant_valid;
    logic         w_grant;
    logic [W-1:0] w_grant_addr;
    logic         w_tmo_hit;
    logic         w_bus_fail;
    logic         w_bus_done;
    logic [W-1:0] w_rdata;
    logic         w_resp;

`ifdef OR1K_TLB_RELOAD_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_tmo;

    // Count BUS cycles; held at zero outside BUS so every access starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_tmo <= '0;
        else if (r_state != ST_BUS) r_tmo <= '0;
        else                       r_tmo <= r_tmo + 8'd1;
    end

    assign w_tmo_hit = (r_state == ST_BUS) && (r_tmo == TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    assign w_owner_req  = (r_owner == OWN_DMMU) ? bus.dmmu_req_i  : bus.immu_req_i;
    assign w_owner_addr = (r_owner == OWN_DMMU) ? bus.dmmu_addr_i : bus.immu_addr_i;

    // Round robin on contention: the walker not served last wins.
    assign w_grant_valid = bus.immu_req_i | bus.dmmu_req_i;
    assign w_grant       = (bus.immu_req_i && bus.dmmu_req_i) ? ~r_last : bus.dmmu_req_i;
    assign w_grant_addr  = (w_grant == OWN_DMMU) ? bus.dmmu_addr_i : bus.immu_addr_i;

    // Error (or timeout) wins over a simultaneous ack and returns a zero word,
    // which the walker decodes as a null pointer / not-present PTE.
    assign w_bus_fail = bus.wbm_err_i | w_tmo_hit;
    assign w_bus_done = bus.wbm_ack_i | w_bus_fail;
    assign w_rdata    = w_bus_fail ? '0 : bus.wbm_dat_i;

    // Sequencing of grant, bus access, response and walk lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_DMMU;
            r_last      <= OWN_IMMU;
            r_adr       <= '0;
            r_cyc       <= 1'b0;
            r_err       <= 1'b0;
            r_immu_data <= '0;
            r_dmmu_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant;
                        r_adr   <= w_grant_addr[W-1:2];
                        r_cyc   <= 1'b1;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (w_bus_done) begin
                        r_cyc <= 1'b0;
                        r_err <= w_bus_fail;
                        if (r_owner == OWN_DMMU) r_dmmu_data <= w_rdata;
                        else                     r_immu_data <= w_rdata;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_last  <= r_owner;
                    r_state <= ST_LOCK;
                end
                ST_LOCK: begin
                    if (w_owner_req) begin
                        r_adr   <= w_owner_addr[W-1:2];
                        r_cyc   <= 1'b1;
                        r_state <= ST_BUS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A walker that gave up during the access gets no ack; the FSM still
    // walks RESP -> LOCK so the bus side is unaffected.
    assign w_resp = (r_state == ST_RESP) && w_owner_req;

    assign bus.immu_ack_o  = w_resp && (r_owner == OWN_IMMU);
    assign bus.dmmu_ack_o  = w_resp && (r_owner == OWN_DMMU);
    assign bus.immu_err_o  = bus.immu_ack_o && r_err;
    assign bus.dmmu_err_o  = bus.dmmu_ack_o && r_err;
    assign bus.immu_data_o = r_immu_data;
    assign bus.dmmu_data_o = r_dmmu_data;

    assign bus.wbm_adr_o = {r_adr, 2'b00};
    assign bus.wbm_cyc_o = r_cyc;
    assign bus.wbm_stb_o = r_cyc;
    assign bus.wbm_we_o  = 1'b0;
    assign bus.wbm_sel_o = 4'hF;
    assign bus.busy_o    = (r_state != ST_IDLE);
endmodule

// File: doc/or1k_tlb_reload_arbiter.md
Name: or1k_tlb_reload_arbiter

Overview:
Shared bus master for the hardware TLB reload walkers. Sits directly downstream of the IMMU and DMMU reload ports: it consumes each walker's req/addr, arbitrates between them, and runs single-word Wishbone classic reads. Each returned word goes back to the owning walker as a one-cycle ack with data. Grant is locked to one walker for the whole multi-access page walk (PTE pointer, then PTE).

Parameters:
OPTION_OPERAND_WIDTH, 32, address/data width
TIMEOUT_CYCLES, 255, bus watchdog limit in clk cycles (used only with the optional feature; max 255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
immu_req_i  in  1  IMMU reload request, level, held for the whole walk
immu_addr_i  in  OPTION_OPERAND_WIDTH  IMMU reload word address
immu_ack_o  out  1  one-cycle ack to IMMU
immu_data_o  out  OPTION_OPERAND_WIDTH  read data to IMMU, valid with ack
immu_err_o  out  1  one-cycle bus error/timeout flag, coincident with ack
dmmu_req_i  in  1  DMMU reload request
dmmu_addr_i  in  OPTION_OPERAND_WIDTH  DMMU reload word address
dmmu_ack_o  out  1  one-cycle ack to DMMU
dmmu_data_o  out  OPTION_OPERAND_WIDTH  read data to DMMU
dmmu_err_o  out  1  bus error/timeout flag to DMMU
wbm_adr_o  out  OPTION_OPERAND_WIDTH  Wishbone address, [1:0] forced to 0
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe, always equal to cyc
wbm_we_o  out  1  constant 0
wbm_sel_o  out  4  constant 4'hF
wbm_dat_i  in  OPTION_OPERAND_WIDTH  Wishbone read data
wbm_ack_i  in  1  Wishbone ack
wbm_err_i  in  1  Wishbone error
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. All outputs 0: cyc, stb, adr, acks, errs, data, busy. owner=DMMU, last_grant=IMMU.
- States: IDLE, BUS, RESP, LOCK.
- IDLE: sample requests.
  - Only one req high: grant it.
  - Both high: grant the requestor that was not last_grant (round robin). First contention after reset grants DMMU.
  - On grant: latch owner and the owner's addr, assert cyc/stb, go to BUS. Bus cycle starts the clock after req is seen (1-cycle request latency).
- BUS: cyc/stb held; adr is stable from the latched copy and ignores later input changes.
  - wbm_ack_i: capture wbm_dat_i, drop cyc/stb, go to RESP.
  - wbm_err_i: drop cyc/stb, capture data=0, set err, go to RESP.
  - ack and err high together: err wins.
- RESP: owner's ack_o=1 for exactly this cycle, with data_o (and err_o if set). data_o holds its value afterwards; non-owner outputs stay 0. Update last_grant=owner. Go to LOCK.
- LOCK: one cycle, lets the walker update addr or drop req on the ack edge.
  - owner req still high: latch new addr, assert cyc/stb, go to BUS. The other requestor is not considered; the walk is atomic.
  - owner req low: go to IDLE. A pending other req is granted from IDLE on the next cycle.
- Owner drops req while in BUS: the bus cycle still completes (no Wishbone abort). The RESP ack/err is suppressed if owner req is low in RESP; the state sequence is unchanged.
- Minimum turnaround for back-to-back accesses of one walk: ack_i edge → RESP → LOCK → cyc again, i.e. 2 idle bus cycles.
- wbm_ack_i/wbm_err_i arriving outside BUS: ignored.
- Error data=0 makes a DMMU walker see a null PTE pointer / not-present PTE and raise a pagefault.

Optional Feature:
OR1K_TLB_RELOAD_TIMEOUT_EN
- Defined: an 8-bit counter clears on entry to BUS and increments each BUS cycle. When it reaches TIMEOUT_CYCLES with no ack/err, cyc/stb drop and the access is treated exactly as wbm_err_i (data 0, err pulse in RESP).
- Undefined: no counter; BUS waits indefinitely.

Test Plan:
- DMMU single walk: dmmu_req=1, addr=0x1000_0040; slave acks after 3 cycles with 0x0040_2000. Then addr=0x0040_2008, second ack with 0x0001_2400, then req drops → two Wishbone reads at those addresses, dmmu_ack pulses twice with those data, immu_ack stays 0, busy returns 0.
- Contention: both reqs rise in the same cycle after reset → DMMU granted first. IMMU granted in the cycle after the DMMU walk ends (LOCK→IDLE→BUS). A new IMMU req raised mid-DMMU-walk is not granted until the walk finishes.
- Round robin: after a DMMU walk completes, both reqs high in IDLE → IMMU granted.
- Bus error: wbm_err_i=1 on a DMMU read → dmmu_ack=1, dmmu_err=1, dmmu_data=0 in the same cycle. With ack+err together, err still reported.
- Abort: DMMU drops req during BUS → bus cycle completes on slave ack, no dmmu_ack pulse, state returns to IDLE. Async rst_n low mid-BUS → cyc=0 immediately.
- With OR1K_TLB_RELOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks → cyc drops after 4 BUS cycles, owner gets ack+err with data 0.
